sprite_path_seq: RTL and testbench
==================================

SPRITE_PATH_SEQ -- requirements
Module: sprite_path_seq

Interface
REQ-001 SHALL have parameter NUM_SEG, default 8, number of path segments in the table (2..16).
REQ-002 SHALL have parameter COORD_W, default 10, width of screen coordinates.
REQ-003 SHALL have parameter FRAME_W, default 5, width of sprite frame index.
REQ-004 SHALL have parameter LEN_W, default 4, width of per-segment step count.
REQ-005 SHALL have parameter DELTA_W, default 6, width of signed per-step deltas.
REQ-006 SHALL have port ANIM_Clk  input  1  animation tick clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset  input  1  reset Reset, asynchronous, active-high.
REQ-008 SHALL have port Run  input  1  level; start playback from IDLE, return to IDLE from HOLD when low.
REQ-009 SHALL have port Pause  input  1  level; freezes PLAY without changing any output.
REQ-010 SHALL have port Loop  input  1  sampled at end of last segment; 1 restarts at segment 0.
REQ-011 SHALL have port Wr_En  input  1  table write strobe.
REQ-012 SHALL have port Wr_Addr  input  $clog2(NUM_SEG)  segment index to write.
REQ-013 SHALL have ports Wr_X, Wr_Y  input  COORD_W each  segment start position.
REQ-014 SHALL have ports Wr_DX, Wr_DY  input  DELTA_W each, signed  per-step displacement.
REQ-015 SHALL have ports Wr_Frame  input  FRAME_W and Wr_Len  input  LEN_W  segment frame and step count.
REQ-016 SHALL have ports Sprite_X, Sprite_Y  output  COORD_W  current position; Frame  output  FRAME_W.
REQ-017 SHALL have ports Seg_Idx  output  $clog2(NUM_SEG); Step_Cnt  output  LEN_W; Busy, Done  output  1.

Function
REQ-018 SHALL implement FSM IDLE, LOAD, PLAY, HOLD; Busy = (state != IDLE).
REQ-019 IDLE: outputs SHALL show segment 0 start X/Y/frame, Seg_Idx=0, Step_Cnt=0; Run=1 -> LOAD next tick.
REQ-020 LOAD (one tick): SHALL latch entry[Seg_Idx] into position/frame, Step_Cnt=0; Len=0 (terminator) -> HOLD with Done, else -> PLAY.
REQ-021 PLAY, Pause=1: SHALL hold all registers and outputs unchanged.
REQ-022 PLAY, Step_Cnt < Len-1: SHALL add sign-extended DX/DY to X/Y, increment Step_Cnt.
REQ-023 PLAY, Step_Cnt == Len-1: Seg_Idx < NUM_SEG-1 -> Seg_Idx+1, LOAD; else end-of-path.
REQ-024 End-of-path: Loop=1 -> Seg_Idx=0, LOAD, no Done; Loop=0 -> HOLD, Done=1 for exactly one tick.
REQ-025 Coordinate arithmetic SHALL wrap modulo 2^COORD_W; no saturation.
REQ-026 HOLD: SHALL keep last X/Y/Frame; Run=0 -> IDLE next tick.
REQ-027 Table writes SHALL be accepted only when Busy=0 and Wr_Addr < NUM_SEG; otherwise ignored; visible next tick.
REQ-028 Pause and end-of-segment in same tick: Pause SHALL win.

Reset
REQ-029 Reset SHALL force IDLE, Seg_Idx=0, Step_Cnt=0, Done=0, all table entries to zero (Len=0).
REQ-030 Reset asserted mid-PLAY SHALL abort immediately; no Done pulse.

Configuration
REQ-031 With SPRITE_SEQ_MIRROR_EN defined: input Mirror (1 bit) SHALL exist; when 1, Sprite_X = (2^COORD_W-1) - internal X, latched at LOAD.
REQ-032 Without SPRITE_SEQ_MIRROR_EN: no Mirror port; Sprite_X = internal X.

Structure
REQ-033 Package sprite_seq_pkg SHALL hold state enum and seg_entry_t struct (x, y, dx, dy, frame, len) parameterised by default widths.
REQ-034 Sub-module sprite_seg_table SHALL hold the NUM_SEG-entry register file: one write port, one combinational read port.

Verification
REQ-035 Load seg0 (X=11,Y=290,DX=8,DY=0,Frame=1,Len=4), seg1 Len=0; Run=1 -> X 11,19,27,35 then HOLD, Done one tick.
REQ-036 Seg0 as above, seg1 (X=267,Y=290,DX=9,DY=-14,Len=3), Loop=1 -> after seg1 returns to X=11, Done never 1.
REQ-037 Pause=1 for 5 ticks mid-seg0 at X=19 -> X stays 19, Step_Cnt stays 1; resumes at 27.
REQ-038 X=1020, DX=+8, Len=2 -> X goes 1020 then 4 (wrap).
REQ-039 Wr_En while Busy=1 with Wr_Len=7 -> table unchanged after return to IDLE; Reset mid-PLAY -> IDLE, Done=0.
REQ-040 With SPRITE_SEQ_MIRROR_EN, Mirror=1, X=11 -> Sprite_X=1012.

Source files
------------

// File: rtl/sprite_seq_pkg.sv
// rtl/sprite_seq_pkg.sv - shared types and default widths for the sprite path sequencer
package sprite_seq_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_FRAME_W = 5;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_DELTA_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_HOLD
    } seq_state_e;

    typedef struct packed {
        logic [DEF_COORD_W-1:0]        x;
        logic [DEF_COORD_W-1:0]        y;
        logic signed [DEF_DELTA_W-1:0] dx;
        logic signed [DEF_DELTA_W-1:0] dy;
        logic [DEF_FRAME_W-1:0]        frame;
        logic [DEF_LEN_W-1:0]          len;
    } seg_entry_t;

endpackage

// File: rtl/sprite_seg_table.sv
// rtl/sprite_seg_table.sv - segment register file, one write port, one combinational read port
module sprite_seg_table #(
    parameter int NUM_SEG = 8,
    parameter int COORD_W = 10,
    parameter int FRAME_W = 5,
    parameter int LEN_W   = 4,
    parameter int DELTA_W = 6,
    localparam int AW     = $clog2(NUM_SEG)
) (
    input  logic               ANIM_Clk,
    input  logic               Reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [DELTA_W-1:0] wr_dx,
    input  logic [DELTA_W-1:0] wr_dy,
    input  logic [FRAME_W-1:0] wr_frame,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic [AW-1:0]      rd_addr,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic [DELTA_W-1:0] rd_dx,
    output logic [DELTA_W-1:0] rd_dy,
    output logic [FRAME_W-1:0] rd_frame,
    output logic [LEN_W-1:0]   rd_len
);

    logic [COORD_W-1:0] x_q     [NUM_SEG];
    logic [COORD_W-1:0] x_d     [NUM_SEG];
    logic [COORD_W-1:0] y_q     [NUM_SEG];
    logic [COORD_W-1:0] y_d     [NUM_SEG];
    logic [DELTA_W-1:0] dx_q    [NUM_SEG];
    logic [DELTA_W-1:0] dx_d    [NUM_SEG];
    logic [DELTA_W-1:0] dy_q    [NUM_SEG];
    logic [DELTA_W-1:0] dy_d    [NUM_SEG];
    logic [FRAME_W-1:0] frame_q [NUM_SEG];
    logic [FRAME_W-1:0] frame_d [NUM_SEG];
    logic [LEN_W-1:0]   len_q   [NUM_SEG];
    logic [LEN_W-1:0]   len_d   [NUM_SEG];
    logic               wr_hit;

    // Addresses past the table are dropped rather than aliased.
    assign wr_hit = wr_en && (int'(wr_addr) < NUM_SEG);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        frame_d = frame_q;
        len_d   = len_q;
        if (wr_hit) begin
            x_d[wr_addr]     = wr_x;
            y_d[wr_addr]     = wr_y;
            dx_d[wr_addr]    = wr_dx;
            dy_d[wr_addr]    = wr_dy;
            frame_d[wr_addr] = wr_frame;
            len_d[wr_addr]   = wr_len;
        end
    end

    always_ff @(posedge ANIM_Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                dx_q[i]    <= '0;
                dy_q[i]    <= '0;
                frame_q[i] <= '0;
                len_q[i]   <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            frame_q <= frame_d;
            len_q   <= len_d;
        end
    end

    assign rd_x     = x_q[rd_addr];
    assign rd_y     = y_q[rd_addr];
    assign rd_dx    = dx_q[rd_addr];
    assign rd_dy    = dy_q[rd_addr];
    assign rd_frame = frame_q[rd_addr];
    assign rd_len   = len_q[rd_addr];

endmodule

// File: rtl/sprite_path_seq.sv
// rtl/sprite_path_seq.sv - table-driven sprite path playback sequencer
// Optional horizontal mirroring under SPRITE_SEQ_MIRROR_EN.
module sprite_path_seq
    import sprite_seq_pkg::*;
#(
    parameter int NUM_SEG = 8,
    parameter int COORD_W = DEF_COORD_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DELTA_W = DEF_DELTA_W,
    localparam int SEG_W  = $clog2(NUM_SEG)
) (
    input  logic               ANIM_Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Pause,
    input  logic               Loop,
`ifdef SPRITE_SEQ_MIRROR_EN
    input  logic               Mirror,
`endif
    input  logic               Wr_En,
    input  logic [SEG_W-1:0]   Wr_Addr,
    input  logic [COORD_W-1:0] Wr_X,
    input  logic [COORD_W-1:0] Wr_Y,
    input  logic [DELTA_W-1:0] Wr_DX,
    input  logic [DELTA_W-1:0] Wr_DY,
    input  logic [FRAME_W-1:0] Wr_Frame,
    input  logic [LEN_W-1:0]   Wr_Len,
    output logic [COORD_W-1:0] Sprite_X,
    output logic [COORD_W-1:0] Sprite_Y,
    output logic [FRAME_W-1:0] Frame,
    output logic [SEG_W-1:0]   Seg_Idx,
    output logic [LEN_W-1:0]   Step_Cnt,
    output logic               Busy,
    output logic               Done
);

    localparam int EXT_W = COORD_W - DELTA_W;

    seq_state_e         state_q, state_d;
    logic [SEG_W-1:0]   seg_idx_q, seg_idx_d;
    logic [LEN_W-1:0]   step_cnt_q, step_cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               done_q, done_d;
    logic [COORD_W-1:0] rd_x, rd_y, dx_ext, dy_ext, pos_x;
    logic [DELTA_W-1:0] rd_dx, rd_dy;
    logic [FRAME_W-1:0] rd_frame;
    logic [LEN_W-1:0]   rd_len;
    logic               idle;
`ifdef SPRITE_SEQ_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif

    sprite_seg_table #(
        .NUM_SEG (NUM_SEG),
        .COORD_W (COORD_W),
        .FRAME_W (FRAME_W),
        .LEN_W   (LEN_W),
        .DELTA_W (DELTA_W)
    ) u_table (
        .ANIM_Clk (ANIM_Clk),
        .Reset    (Reset),
        .wr_en    (Wr_En && !Busy),
        .wr_addr  (Wr_Addr),
        .wr_x     (Wr_X),
        .wr_y     (Wr_Y),
        .wr_dx    (Wr_DX),
        .wr_dy    (Wr_DY),
        .wr_frame (Wr_Frame),
        .wr_len   (Wr_Len),
        .rd_addr  (seg_idx_q),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_dx    (rd_dx),
        .rd_dy    (rd_dy),
        .rd_frame (rd_frame),
        .rd_len   (rd_len)
    );

    assign dx_ext = {{EXT_W{rd_dx[DELTA_W-1]}}, rd_dx};
    assign dy_ext = {{EXT_W{rd_dy[DELTA_W-1]}}, rd_dy};

    always_comb begin
        state_d    = state_q;
        seg_idx_d  = seg_idx_q;
        step_cnt_d = step_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
`ifdef SPRITE_SEQ_MIRROR_EN
        mirror_d   = mirror_q;
`endif
        case (state_q)
            ST_IDLE: begin
                seg_idx_d  = '0;
                step_cnt_d = '0;
                if (Run) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                step_cnt_d = '0;
                // A zero-length entry terminates the path; position stays at the last drawn point.
                if (rd_len == '0) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end else begin
                    x_d     = rd_x;
                    y_d     = rd_y;
                    frame_d = rd_frame;
`ifdef SPRITE_SEQ_MIRROR_EN
                    mirror_d = Mirror;
`endif
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!Pause) begin
                    if (step_cnt_q < rd_len - LEN_W'(1)) begin
                        x_d        = x_q + dx_ext;
                        y_d        = y_q + dy_ext;
                        step_cnt_d = step_cnt_q + LEN_W'(1);
                    end else if (seg_idx_q < SEG_W'(NUM_SEG - 1)) begin
                        seg_idx_d  = seg_idx_q + SEG_W'(1);
                        step_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end else if (Loop) begin
                        seg_idx_d  = '0;
                        step_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!Run) begin
                    state_d    = ST_IDLE;
                    seg_idx_d  = '0;
                    step_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ANIM_Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            seg_idx_q  <= '0;
            step_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            done_q     <= 1'b0;
`ifdef SPRITE_SEQ_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seg_idx_q  <= seg_idx_d;
            step_cnt_q <= step_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
`ifdef SPRITE_SEQ_MIRROR_EN
            mirror_q   <= mirror_d;
`endif
        end
    end

    // While idle the table is read at segment 0, so the start point tracks table writes.
    assign idle  = (state_q == ST_IDLE);
    assign pos_x = idle ? rd_x : x_q;

`ifdef SPRITE_SEQ_MIRROR_EN
    assign Sprite_X = (idle ? Mirror : mirror_q) ? ~pos_x : pos_x;
`else
    assign Sprite_X = pos_x;
`endif
    assign Sprite_Y = idle ? rd_y : y_q;
    assign Frame    = idle ? rd_frame : frame_q;
    assign Seg_Idx  = seg_idx_q;
    assign Step_Cnt = step_cnt_q;
    assign Busy     = !idle;
    assign Done     = done_q;

endmodule

// File: tb/tb_sprite_path_seq.sv
// tb/tb_sprite_path_seq.sv - scoreboard bench for sprite_path_seq (two-segment table)
module tb_sprite_path_seq;

    localparam int NUM_SEG = 2;

    logic       ANIM_Clk = 1'b0;
    logic       Reset    = 1'b1;
    logic       Run      = 1'b0;
    logic       Pause    = 1'b0;
    logic       Loop     = 1'b0;
    logic       Wr_En    = 1'b0;
    logic [0:0] Wr_Addr  = '0;
    logic [9:0] Wr_X     = '0;
    logic [9:0] Wr_Y     = '0;
    logic [5:0] Wr_DX    = '0;
    logic [5:0] Wr_DY    = '0;
    logic [4:0] Wr_Frame = '0;
    logic [3:0] Wr_Len   = '0;
    logic [9:0] Sprite_X, Sprite_Y;
    logic [4:0] Frame;
    logic [0:0] Seg_Idx;
    logic [3:0] Step_Cnt;
    logic       Busy, Done;
`ifdef SPRITE_SEQ_MIRROR_EN
    logic       Mirror = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         chk_pos;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] fr;
        logic [3:0] st;
        logic [0:0] sg;
        logic       bz;
        logic       dn;
    } exp_t;

    exp_t sb[$];

    sprite_path_seq #(.NUM_SEG(NUM_SEG)) dut (
        .ANIM_Clk (ANIM_Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Pause    (Pause),
        .Loop     (Loop),
`ifdef SPRITE_SEQ_MIRROR_EN
        .Mirror   (Mirror),
`endif
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_X     (Wr_X),
        .Wr_Y     (Wr_Y),
        .Wr_DX    (Wr_DX),
        .Wr_DY    (Wr_DY),
        .Wr_Frame (Wr_Frame),
        .Wr_Len   (Wr_Len),
        .Sprite_X (Sprite_X),
        .Sprite_Y (Sprite_Y),
        .Frame    (Frame),
        .Seg_Idx  (Seg_Idx),
        .Step_Cnt (Step_Cnt),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 ANIM_Clk = ~ANIM_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit c, input int x, input int y, input int fr,
                        input int st, input int sg, input bit bz, input bit dn);
        exp_t e;
        e.chk_pos = c;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.fr = 5'(fr);
        e.st = 4'(st);
        e.sg = 1'(sg);
        e.bz = bz;
        e.dn = dn;
        sb.push_back(e);
    endtask

    // One scoreboard entry per tick, sampled on the falling edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge ANIM_Clk);
            e = sb.pop_front();
            if (e.chk_pos) begin
                chk("sprite_x", Sprite_X, e.x);
                chk("sprite_y", Sprite_Y, e.y);
                chk("frame", Frame, e.fr);
            end
            chk("step_cnt", Step_Cnt, e.st);
            chk("seg_idx", Seg_Idx, e.sg);
            chk("busy", Busy, e.bz);
            chk("done", Done, e.dn);
        end
    endtask

    task automatic write_seg(input int a, input int x, input int y, input int dx,
                             input int dy, input int fr, input int len);
        Wr_En    = 1'b1;
        Wr_Addr  = 1'(a);
        Wr_X     = 10'(x);
        Wr_Y     = 10'(y);
        Wr_DX    = 6'(dx);
        Wr_DY    = 6'(dy);
        Wr_Frame = 5'(fr);
        Wr_Len   = 4'(len);
        @(negedge ANIM_Clk);
        Wr_En    = 1'b0;
    endtask

    initial begin
        @(negedge ANIM_Clk);
        @(negedge ANIM_Clk);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_seg", Seg_Idx, 0);
        chk("reset_step", Step_Cnt, 0);
        chk("reset_x", Sprite_X, 0);
        chk("reset_frame", Frame, 0);
        Reset = 1'b0;
        @(negedge ANIM_Clk);

        // Single segment then terminator
        write_seg(0, 11, 290, 8, 0, 1, 4);
        write_seg(1, 0, 0, 0, 0, 0, 0);
        push(1, 11, 290, 1, 0, 0, 0, 0);
        drain();
        Run = 1'b1;
        push(0, 0, 0, 0, 0, 0, 1, 0);
        push(1, 11, 290, 1, 0, 0, 1, 0);
        push(1, 19, 290, 1, 1, 0, 1, 0);
        push(1, 27, 290, 1, 2, 0, 1, 0);
        push(1, 35, 290, 1, 3, 0, 1, 0);
        push(1, 35, 290, 1, 0, 1, 1, 0);
        push(1, 35, 290, 1, 0, 1, 1, 1);
        drain();
        // Write attempt while busy must be ignored
        Wr_En = 1'b1; Wr_Addr = 1'b0; Wr_X = 10'd500; Wr_Len = 4'd7;
        push(1, 35, 290, 1, 0, 1, 1, 0);
        drain();
        Wr_En = 1'b0;
        Run   = 1'b0;
        push(1, 11, 290, 1, 0, 0, 0, 0);
        drain();

        // Two segments with looping
        write_seg(1, 267, 290, 9, -14, 2, 3);
        Run  = 1'b1;
        Loop = 1'b1;
        push(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) push(1, 11 + 8 * i, 290, 1, i, 0, 1, 0);
        push(1, 35, 290, 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) push(1, 267 + 9 * i, 290 - 14 * i, 2, i, 1, 1, 0);
        push(1, 285, 262, 2, 0, 0, 1, 0);
        push(1, 11, 290, 1, 0, 0, 1, 0);
        drain();
        Loop = 1'b0;
        Run  = 1'b0;
        for (int i = 1; i < 4; i++) push(1, 11 + 8 * i, 290, 1, i, 0, 1, 0);
        push(1, 35, 290, 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) push(1, 267 + 9 * i, 290 - 14 * i, 2, i, 1, 1, 0);
        push(1, 285, 262, 2, 2, 1, 1, 1);
        push(1, 11, 290, 1, 0, 0, 0, 0);
        drain();

        // Pause mid-segment and at end of segment
        Run = 1'b1;
        push(0, 0, 0, 0, 0, 0, 1, 0);
        push(1, 11, 290, 1, 0, 0, 1, 0);
        push(1, 19, 290, 1, 1, 0, 1, 0);
        drain();
        Pause = 1'b1;
        for (int i = 0; i < 5; i++) push(1, 19, 290, 1, 1, 0, 1, 0);
        drain();
        Pause = 1'b0;
        push(1, 27, 290, 1, 2, 0, 1, 0);
        push(1, 35, 290, 1, 3, 0, 1, 0);
        drain();
        Pause = 1'b1;
        push(1, 35, 290, 1, 3, 0, 1, 0);
        drain();
        Pause = 1'b0;
        push(1, 35, 290, 1, 0, 1, 1, 0);
        push(1, 267, 290, 2, 0, 1, 1, 0);
        drain();

        // Asynchronous reset mid-play
        Run   = 1'b0;
        Reset = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_seg", Seg_Idx, 0);
        chk("abort_step", Step_Cnt, 0);
        chk("abort_x_cleared", Sprite_X, 0);
        @(negedge ANIM_Clk);
        Reset = 1'b0;
        push(1, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Coordinate wrap
        write_seg(0, 1020, 5, 8, 0, 3, 2);
        Run = 1'b1;
        push(0, 0, 0, 0, 0, 0, 1, 0);
        push(1, 1020, 5, 3, 0, 0, 1, 0);
        push(1, 4, 5, 3, 1, 0, 1, 0);
        push(1, 4, 5, 3, 0, 1, 1, 0);
        push(1, 4, 5, 3, 0, 1, 1, 1);
        drain();
        Run = 1'b0;
        push(1, 1020, 5, 3, 0, 0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
